ser2par_flex: RTL
=================

SER2PAR_FLEX -- requirements
Module: ser2par_flex

Interface
REQ-001 Parameter W, default 8, meaning output word width in bits; W >= 2.
REQ-002 Parameter LANES, default 1, meaning serial bits accepted per valid beat; W % LANES == 0 (elaboration error otherwise).
REQ-003 Parameter MSB_FIRST, default 1, meaning 1 = first beat lands in most-significant bits, 0 = first beat lands in least-significant bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 ser_din  input  LANES  serial data beat.
REQ-007 ser_din_valid  input  1  ser_din qualifier; beat captured on each rising edge where high.
REQ-008 flush  input  1  emit the current partial word at this edge.
REQ-009 par_dout  output  W  assembled word.
REQ-010 par_dout_valid  output  1  par_dout holds an unconsumed word.
REQ-011 par_dout_ready  input  1  consumer accepts; transfer on edge with valid && ready.
REQ-012 par_dout_bits  output  $clog2(W+1)  count of meaningful bits in par_dout (W for full words).
REQ-013 overflow  output  1  sticky: a completed word was dropped.
REQ-014 overflow_clr  input  1  clears overflow.

Function
REQ-015 Accumulator holds up to W/LANES beats; beat counter counts 0..W/LANES-1, wraps to 0 on word completion.
REQ-016 MSB_FIRST=1: word = {beat0, beat1, ...}; ser_din[LANES-1] is most significant within a beat.
REQ-017 MSB_FIRST=0: beat k occupies bits [k*LANES+LANES-1 : k*LANES], ser_din[0] at lowest bit of the slot.
REQ-018 Word completes at the edge capturing beat W/LANES-1; at that same edge the word loads into the output register; par_dout_valid is high in the following cycle (latency 1 edge, no further pipeline).
REQ-019 Gaps (ser_din_valid low) do not disturb accumulator or counter.
REQ-020 Output register has one entry; par_dout, par_dout_bits held stable while valid && !ready.
REQ-021 Output register is free at an edge if !par_dout_valid or par_dout_ready; a completed word at that edge loads with no overflow (simultaneous consume and load allowed).
REQ-022 Completed word arriving while output register not free: word dropped, held word unchanged, overflow set, counter still wraps to 0.
REQ-023 flush with a valid beat at the same edge: beat included first, then the flushed word formed.
REQ-024 flush with 0 accumulated bits (after including any same-edge beat): no output, no state change.
REQ-025 Partial flushed word: MSB_FIRST=1 collected bits left-aligned with zeros below; MSB_FIRST=0 collected bits right-aligned with zeros above; par_dout_bits = beats*LANES; counter returns to 0.
REQ-026 flush on a completing beat behaves as a normal full-word completion (par_dout_bits = W).
REQ-027 Flushed word subject to same free/overflow rules as REQ-021/022.
REQ-028 overflow_clr and a new overflow event at the same edge: overflow remains 1.

Reset
REQ-029 rstn low asynchronously forces: par_dout = 0, par_dout_valid = 0, par_dout_bits = 0, overflow = 0, beat counter = 0, accumulator = 0.
REQ-030 Reset mid-word discards the partial word; first beat after release is beat0 of a new word.

Verification
REQ-031 W=8,LANES=1,MSB_FIRST=1, ready=1: beats 0,1,1,1, one gap cycle, 0,0,0,1 -> single par_dout=0x71, bits=8, valid one cycle.
REQ-032 Same stimulus, MSB_FIRST=0 -> par_dout=0x8E, bits=8.
REQ-033 MSB_FIRST=1: beats 1,0,1 then flush alone -> par_dout=0xA0, bits=3; next 8 beats form a fresh full word.
REQ-034 ready=0, two full words streamed -> first word held stable, second dropped, overflow=1; ready=1 transfers first word; overflow_clr -> overflow=0.
REQ-035 W=8,LANES=2,MSB_FIRST=1: beats 2'b11,2'b00,2'b10,2'b01 -> par_dout=0xC9; word completing on the same edge as consume of previous word -> no overflow.
REQ-036 rstn pulsed low after 5 beats -> all outputs 0 immediately; 8 following beats yield one correct word.

Source files
------------

// File: rtl/ser2par_flex.sv
// Serial-to-parallel converter: gathers LANES-bit beats into W-bit words with
// partial-word flush, a one-entry ready/valid output register and sticky overflow.
module ser2par_flex #(
    parameter int unsigned W         = 8,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [LANES-1:0]       ser_din,
    input  logic                   ser_din_valid,
    input  logic                   flush,
    output logic [W-1:0]           par_dout,
    output logic                   par_dout_valid,
    input  logic                   par_dout_ready,
    output logic [$clog2(W+1)-1:0] par_dout_bits,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam int unsigned BEATS = W / LANES;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam int unsigned BW    = $clog2(W + 1);
    localparam int unsigned IW    = $clog2(W);

    if ((W % LANES) != 0 || W < 2) begin : g_bad_params
        $error("ser2par_flex: W must be >= 2 and a multiple of LANES");
    end

    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             vld_q, vld_d;
    logic [BW-1:0]    bits_q, bits_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     acc_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic [IW-1:0]    slot_lo;
    logic             complete;
    logic             emit;
    logic             out_free;
    logic [BW-1:0]    emit_bits;

    // Beat placement, word completion/flush and output-register handoff.
    always_comb begin
        acc_upd   = acc_q;
        cnt_upd   = cnt_q;
        slot_lo   = '0;
        complete  = 1'b0;
        emit      = 1'b0;
        emit_bits = '0;
        out_free  = !vld_q || par_dout_ready;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        vld_d     = vld_q && !par_dout_ready;
        bits_d    = bits_q;
        ovf_d     = ovf_q && !overflow_clr;

        if (MSB_FIRST) begin
            slot_lo = IW'(W - LANES - 32'(cnt_q) * LANES);
        end else begin
            slot_lo = IW'(32'(cnt_q) * LANES);
        end

        if (ser_din_valid) begin
            acc_upd[slot_lo +: LANES] = ser_din;
            cnt_upd                   = cnt_q + CNT_W'(1);
            complete                  = (cnt_q == CNT_W'(BEATS - 1));
        end

        emit      = complete || (flush && cnt_upd != '0);
        emit_bits = complete ? BW'(W) : BW'(32'(cnt_upd) * LANES);

        if (emit) begin
            // Accumulator always restarts, whether or not the word was accepted.
            acc_d = '0;
            cnt_d = '0;
            if (out_free) begin
                dout_d = acc_upd;
                bits_d = emit_bits;
                vld_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            acc_d = acc_upd;
            cnt_d = cnt_upd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            bits_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            bits_q <= bits_d;
            ovf_q  <= ovf_d;
        end
    end

    assign par_dout       = dout_q;
    assign par_dout_valid = vld_q;
    assign par_dout_bits  = bits_q;
    assign overflow       = ovf_q;

endmodule
